// File: rtl/cv32e40x_log_arbiter_pkg.sv
// Shared types for the trace-log arbiter: the queued log record and the event codes it carries.
// The record gains a timestamp field when CV32E40X_LOG_TIMESTAMP_EN is defined.
package cv32e40x_log_arbiter_pkg;

    // Record source field is sized for the largest supported requester count (8).
    localparam int LOG_SRC_W_MAX = 3;

    localparam logic [7:0] LOG_CODE_ILLEGAL_INSN = 8'h01;
    localparam logic [7:0] LOG_CODE_EXCEPTION    = 8'h02;
    localparam logic [7:0] LOG_CODE_DEBUG_ENTRY  = 8'h03;
    localparam logic [7:0] LOG_CODE_INTERRUPT    = 8'h04;
    localparam logic [7:0] LOG_CODE_EBREAK       = 8'h05;

    typedef struct packed {
        logic [LOG_SRC_W_MAX-1:0] src;
        logic [31:0]              pc;
        logic [7:0]               code;
`ifdef CV32E40X_LOG_TIMESTAMP_EN
        logic [31:0]              ts;
`endif
    } log_rec_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cv32e40x_log_fifo.sv
// Synchronous FIFO of log records with registered storage and no write-to-read bypass.
// Occupancy is tracked as EMPTY / PARTIAL / FULL; the head output holds its last value while empty.
module cv32e40x_log_fifo
    import cv32e40x_log_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  log_rec_t data_i,
    input  logic     pop_i,
    output log_rec_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    log_rec_t         mem_q [DEPTH];
    log_rec_t         hold_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & (state_q != ST_EMPTY);
    assign do_push = push_i & ((state_q != ST_FULL) | do_pop);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (cnt_d == '0) begin
            state_d = ST_EMPTY;
        end else if (cnt_d == CNT_W'(DEPTH)) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_PARTIAL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= ST_EMPTY;
            hold_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q   <= cnt_d;
            state_q <= state_d;
            hold_q  <= data_o;
        end
    end

    // NOTE: the storage array is deliberately not reset; a slot is only visible after it is written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = (state_q == ST_EMPTY) ? hold_q : mem_q[rd_ptr_q];
    assign full_o  = (state_q == ST_FULL);
    assign empty_o = (state_q == ST_EMPTY);

endmodule

// File: rtl/cv32e40x_log_arbiter.sv
// Round-robin arbiter sharing one trace-log sink between NUM_SRC event requesters via a record FIFO.
// Define CV32E40X_LOG_TIMESTAMP_EN to timestamp each record and expose log_ts_o.
module cv32e40x_log_arbiter
    import cv32e40x_log_arbiter_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int DROP_ON_FULL = 0,
    localparam int SRC_W       = $clog2(NUM_SRC)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_SRC-1:0]   src_valid_i,
    input  logic [NUM_SRC*32-1:0] src_pc_i,
    input  logic [NUM_SRC*8-1:0] src_code_i,
    output logic [NUM_SRC-1:0]   src_ready_o,
    output logic                 log_valid_o,
    input  logic                 log_ready_i,
    output logic [SRC_W-1:0]     log_src_o,
    output logic [31:0]          log_pc_o,
    output logic [7:0]           log_code_o,
`ifdef CV32E40X_LOG_TIMESTAMP_EN
    output logic [31:0]          log_ts_o,
`endif
    output logic [15:0]          drop_cnt_o
);

    logic [SRC_W-1:0]   rr_ptr_q, rr_next;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [NUM_SRC-1:0] grant_oh;
    logic               fifo_full, fifo_empty;
    logic               pop, can_push, push, rr_adv;
    log_rec_t           push_rec, head_rec;

    // NOTE: combinational scans use blocking '='; every clocked register uses '<='.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!grant_valid && src_valid_i[(int'(rr_ptr_q) + k) % NUM_SRC]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
            end
        end
    end

    assign grant_oh = grant_valid ? (NUM_SRC'(1) << grant_idx) : '0;
    assign rr_next  = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);

    assign log_valid_o = !fifo_empty;
    assign pop         = log_valid_o & log_ready_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign can_push    = !fifo_full | pop;
    assign push        = grant_valid & can_push;

`ifdef CV32E40X_LOG_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) ts_q <= '0;
        else       ts_q <= ts_q + 32'd1;
    end

    assign log_ts_o = head_rec.ts;
`endif

    always_comb begin
        push_rec      = '0;
        push_rec.src  = LOG_SRC_W_MAX'(grant_idx);
        push_rec.pc   = src_pc_i[int'(grant_idx)*32 +: 32];
        push_rec.code = src_code_i[int'(grant_idx)*8 +: 8];
`ifdef CV32E40X_LOG_TIMESTAMP_EN
        push_rec.ts   = ts_q;
`endif
    end

    generate
        if (DROP_ON_FULL != 0) begin : g_drop
            logic [7:0]  valid_ext;
            logic [3:0]  n_drop;
            logic [16:0] drop_sum;
            logic [15:0] drop_cnt_q;

            // Every valid is consumed; whatever did not make it into the FIFO is counted as dropped.
            always_comb begin
                valid_ext              = '0;
                valid_ext[NUM_SRC-1:0] = src_valid_i;
                n_drop                 = popcount8(valid_ext) - {3'b000, push};
                drop_sum               = {1'b0, drop_cnt_q} + {13'd0, n_drop};
            end

            always_ff @(posedge clk_i) begin
                if (rst_i)             drop_cnt_q <= '0;
                else if (drop_sum[16]) drop_cnt_q <= 16'hFFFF;
                else                   drop_cnt_q <= drop_sum[15:0];
            end

            assign src_ready_o = '1;
            assign rr_adv      = grant_valid;
            assign drop_cnt_o  = drop_cnt_q;
        end else begin : g_backpressure
            assign src_ready_o = (rst_i || !can_push) ? '0 : grant_oh;
            assign rr_adv      = push;
            assign drop_cnt_o  = '0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i)       rr_ptr_q <= '0;
        else if (rr_adv) rr_ptr_q <= rr_next;
    end

    cv32e40x_log_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_rec),
        .pop_i   (pop),
        .data_o  (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign log_src_o  = SRC_W'(head_rec.src);
    assign log_pc_o   = head_rec.pc;
    assign log_code_o = head_rec.code;

endmodule

// File: tb/tb_cv32e40x_log_arbiter.sv
// Directed bench for cv32e40x_log_arbiter: a back-pressure instance and a DROP_ON_FULL instance.
// Timestamp checks are compiled in when CV32E40X_LOG_TIMESTAMP_EN is defined.
module tb_cv32e40x_log_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   valid, d_valid;
    logic         lready, d_lready;
    logic [127:0] pc_bus;
    logic [31:0]  code_bus;

    logic [3:0]   ready, d_ready;
    logic         lvalid, d_lvalid;
    logic [1:0]   lsrc, d_lsrc;
    logic [31:0]  lpc, d_lpc;
    logic [7:0]   lcode, d_lcode;
    logic [15:0]  drop, d_drop;
`ifdef CV32E40X_LOG_TIMESTAMP_EN
    logic [31:0]  lts, d_lts;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cv32e40x_log_arbiter #(.NUM_SRC(4), .FIFO_DEPTH(4), .DROP_ON_FULL(0)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .src_valid_i (valid),
        .src_pc_i    (pc_bus),
        .src_code_i  (code_bus),
        .src_ready_o (ready),
        .log_valid_o (lvalid),
        .log_ready_i (lready),
        .log_src_o   (lsrc),
        .log_pc_o    (lpc),
        .log_code_o  (lcode),
`ifdef CV32E40X_LOG_TIMESTAMP_EN
        .log_ts_o    (lts),
`endif
        .drop_cnt_o  (drop)
    );

    cv32e40x_log_arbiter #(.NUM_SRC(4), .FIFO_DEPTH(4), .DROP_ON_FULL(1)) dut_d (
        .clk_i       (clk),
        .rst_i       (rst),
        .src_valid_i (d_valid),
        .src_pc_i    (pc_bus),
        .src_code_i  (code_bus),
        .src_ready_o (d_ready),
        .log_valid_o (d_lvalid),
        .log_ready_i (d_lready),
        .log_src_o   (d_lsrc),
        .log_pc_o    (d_lpc),
        .log_code_o  (d_lcode),
`ifdef CV32E40X_LOG_TIMESTAMP_EN
        .log_ts_o    (d_lts),
`endif
        .drop_cnt_o  (d_drop)
    );

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       lready;
        logic [3:0] exp_ready;
        logic       exp_lvalid;
        logic [1:0] exp_src;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            pc_bus[i*32 +: 32] = 32'h100 + 32'(i * 16);
            code_bus[i*8 +: 8] = 8'(i + 1);
        end
        rst = 1'b1; valid = '0; d_valid = '0; lready = 1'b0; d_lready = 1'b0;

        // rst, valid, lready, exp_ready, exp_lvalid, exp_src
        tbl[0] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[1] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[2] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[3] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[4] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[5] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[6] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[7] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[8] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[9] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("reset ready",        32'(ready),    32'h0);
        check("reset log_valid",    32'(lvalid),   32'h0);
        check("reset log_pc",       lpc,           32'h0);
        check("reset log_src",      32'(lsrc),     32'h0);
        check("reset drop_cnt",     32'(drop),     32'h0);
        check("reset drop ready",   32'(d_ready),  32'hF);
        check("reset drop lvalid",  32'(d_lvalid), 32'h0);
        check("reset drop_cnt d",   32'(d_drop),   32'h0);

        // Single event, round-robin order and one-cycle latency.
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst; valid = tbl[i].valid; lready = tbl[i].lready;
            #1;
            check($sformatf("tbl%0d ready", i),  32'(ready),  32'(tbl[i].exp_ready));
            check($sformatf("tbl%0d lvalid", i), 32'(lvalid), 32'(tbl[i].exp_lvalid));
            if (tbl[i].exp_lvalid) begin
                check($sformatf("tbl%0d src", i),  32'(lsrc),  32'(tbl[i].exp_src));
                check($sformatf("tbl%0d pc", i),   lpc,        32'h100 + 32'(tbl[i].exp_src) * 16);
                check($sformatf("tbl%0d code", i), 32'(lcode), 32'(tbl[i].exp_src) + 1);
            end
            tick();
        end
        rst = 1'b0;

        // Back-pressure: four accepts into a stalled FIFO, then push+pop while full.
        lready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            valid = 4'b0010;
            pc_bus[63:32] = 32'h200 + 32'((k < 4) ? k : 4);
            #1;
            check($sformatf("fill%0d ready", k), 32'(ready), (k < 4) ? 32'h2 : 32'h0);
            if (k > 0) begin
                check($sformatf("fill%0d lvalid", k), 32'(lvalid), 32'h1);
                check($sformatf("fill%0d head pc", k), lpc, 32'h200);
            end
            tick();
        end
        lready = 1'b1;
        #1;
        check("full pushpop ready", 32'(ready), 32'h2);
        check("full pushpop head",  lpc,        32'h200);
        check("full pushpop src",   32'(lsrc),  32'h1);
        tick();
        valid = '0;
        for (int j = 0; j < 4; j++) begin
            #1;
            check($sformatf("drain%0d lvalid", j), 32'(lvalid), 32'h1);
            check($sformatf("drain%0d pc", j),     lpc,         32'h201 + 32'(j));
            tick();
        end
        #1;
        check("drained lvalid", 32'(lvalid), 32'h0);
        pc_bus[63:32] = 32'h110;

        // Drop mode: counting, full FIFO and saturation.
        d_lready = 1'b0;
        d_valid = 4'b1111;
        #1;
        check("drop ready all", 32'(d_ready), 32'hF);
        tick();
        #1;
        check("drop first +3",  32'(d_drop),   32'h3);
        check("drop head valid", 32'(d_lvalid), 32'h1);
        check("drop head src",  32'(d_lsrc),   32'h0);
        d_valid = 4'b0001;
        repeat (3) tick();
        check("drop fill no drop", 32'(d_drop), 32'h3);
        d_valid = 4'b0111;
        tick();
        check("drop full +3", 32'(d_drop), 32'h6);
        d_valid = 4'b1111;
        repeat (16382) tick();
        check("drop preset FFFE", 32'(d_drop), 32'hFFFE);
        d_valid = 4'b0111;
        tick();
        check("drop saturate",  32'(d_drop), 32'hFFFF);
        d_valid = 4'b1111;
        tick();
        check("drop hold FFFF", 32'(d_drop), 32'hFFFF);
        check("drop head stable", d_lpc, 32'h100);
        d_valid = '0;

        // Reset with queued records.
        lready = 1'b0;
        valid = 4'b0001;
        repeat (3) tick();
        valid = '0;
        #1;
        check("queued lvalid", 32'(lvalid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid-rst lvalid",     32'(lvalid),   32'h0);
        check("mid-rst d lvalid",   32'(d_lvalid), 32'h0);
        check("mid-rst d drop_cnt", 32'(d_drop),   32'h0);
        valid = 4'b1111;
        #1;
        check("mid-rst rr ptr", 32'(ready), 32'h1);
        tick();
        valid = '0;
        #1;
        check("post-rst src", 32'(lsrc), 32'h0);

`ifdef CV32E40X_LOG_TIMESTAMP_EN
        rst = 1'b1; lready = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        valid = 4'b0001;
        tick();
        valid = '0;
        #1;
        check("timestamp cycle 10", lts, 32'd10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
